rsc_net_iface: RTL and testbench

Resource-side network interface for one node of the XY mesh NoC. It sits between a local resource and that node's switch resource port. On transmit, it turns resource payloads plus destination coordinates into NoC packets and writes them into the switch input FIFO under `full` backpressure. On receive, it buffers packets written by the switch, drives `full`/`overflow` back toward the switch, checks the destination address, and hands payloads to the resource over a valid/ready handshake.

---
 rtl/rsc_net_iface.sv | 147 ++++++++++++++
 tb/tb_rsc_net_iface.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsc_net_iface.sv
// Resource-side NoC network interface: TX packetiser with full backpressure,
// RX show-ahead FIFO with overflow flag. Optional RSC_NI_ADDR_CHECK_EN drops misrouted packets.
module rsc_net_iface #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PCKT_XADDR_W    = 2,
  parameter int PCKT_YADDR_W    = 2,
  parameter int PCKT_DATA_W     = 8,
  parameter int PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W,
  parameter int RX_FIFO_DEPTH_W = 3,
  parameter int CNT_W           = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PCKT_DATA_W-1:0]  tx_data_i,
  input  logic [PCKT_XADDR_W-1:0] tx_xaddr_i,
  input  logic [PCKT_YADDR_W-1:0] tx_yaddr_i,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  output logic [PCKT_W-1:0]       noc_pckt_o,
  output logic                    noc_wren_o,
  input  logic                    noc_full_i,
  input  logic                    noc_ovrflw_i,
  input  logic [PCKT_W-1:0]       noc_pckt_i,
  input  logic                    noc_wren_i,
  output logic                    noc_full_o,
  output logic                    noc_ovrflw_o,
  output logic [PCKT_DATA_W-1:0]  rx_data_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output logic                    tx_err_o,
  output logic                    rx_misroute_o,
  output logic [CNT_W-1:0]        tx_pckt_cnt_o,
  output logic [CNT_W-1:0]        rx_pckt_cnt_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;
  localparam int DEPTH = 2 ** RX_FIFO_DEPTH_W;
  localparam logic [RX_FIFO_DEPTH_W:0] FULL_CNT =
    {1'b1, {RX_FIFO_DEPTH_W{1'b0}}};

  logic [0:0]        state_q;
  logic [PCKT_W-1:0] pckt_q;
  logic              tx_load;
  logic              tx_err_q;
  logic [CNT_W-1:0]  tx_cnt_q;

  always_comb begin
    noc_wren_o = (state_q == ST_PEND) & ~noc_full_i;
    tx_ready_o = (state_q == ST_IDLE) | noc_wren_o;
    tx_load    = tx_valid_i & tx_ready_o;
  end

  assign noc_pckt_o    = pckt_q;
  assign tx_err_o      = tx_err_q;
  assign tx_pckt_cnt_o = tx_cnt_q;

  // A firing write with a new offer reloads in place: no idle bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pckt_q  <= '0;
    end else if (tx_load) begin
      state_q <= ST_PEND;
      pckt_q  <= {tx_xaddr_i, tx_yaddr_i, tx_data_i};
    end else if (noc_wren_o) begin
      state_q <= ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_err_q <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      if (noc_ovrflw_i) tx_err_q <= 1'b1;
      if (noc_wren_o)   tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  logic [RX_FIFO_DEPTH_W-1:0] wr_ptr_q;
  logic [RX_FIFO_DEPTH_W-1:0] rd_ptr_q;
  logic [RX_FIFO_DEPTH_W:0]   cnt_q;
  logic [PCKT_DATA_W-1:0]     mem_q [DEPTH];
  logic                       addr_ok;
  logic                       push;
  logic                       pop;
  logic                       ovrflw_q;
  logic [CNT_W-1:0]           rx_cnt_q;

`ifdef RSC_NI_ADDR_CHECK_EN
  logic misroute_q;

  assign addr_ok =
    (noc_pckt_i[PCKT_W-1 -: PCKT_XADDR_W] == PCKT_XADDR_W'(X_CORD)) &&
    (noc_pckt_i[PCKT_W-PCKT_XADDR_W-1 -: PCKT_YADDR_W]
       == PCKT_YADDR_W'(Y_CORD));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     misroute_q <= 1'b0;
    else if (noc_wren_i && !addr_ok) misroute_q <= 1'b1;
  end

  assign rx_misroute_o = misroute_q;
`else
  logic unused_addr;

  assign addr_ok       = 1'b1;
  assign unused_addr   = (^noc_pckt_i[PCKT_W-1:PCKT_DATA_W])
                       ^ (X_CORD == Y_CORD);
  assign rx_misroute_o = 1'b0;
`endif

  assign noc_full_o    = (cnt_q == FULL_CNT);
  assign rx_valid_o    = (cnt_q != '0);
  assign push          = noc_wren_i & ~noc_full_o & addr_ok;
  assign pop           = rx_valid_o & rx_ready_i;
  assign rx_data_o     = rx_valid_o ? mem_q[rd_ptr_q] : '0;
  assign noc_ovrflw_o  = ovrflw_q;
  assign rx_pckt_cnt_o = rx_cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= noc_pckt_i[PCKT_DATA_W-1:0];
  end

  // Full is judged on the current count, so a pop cannot rescue a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovrflw_q <= 1'b0;
      rx_cnt_q <= '0;
    end else begin
      ovrflw_q <= noc_wren_i & noc_full_o;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_rsc_net_iface.sv
// Testbench for rsc_net_iface at node (1,1); TX and RX expectations
// are queued when stimulus is driven and consumed when the DUT produces output.
module tb_rsc_net_iface;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  tx_data_i = '0;
  logic [1:0]  tx_xaddr_i = '0;
  logic [1:0]  tx_yaddr_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [11:0] noc_pckt_o;
  logic        noc_wren_o;
  logic        noc_full_i = 1'b0;
  logic        noc_ovrflw_i = 1'b0;
  logic [11:0] noc_pckt_i = '0;
  logic        noc_wren_i = 1'b0;
  logic        noc_full_o;
  logic        noc_ovrflw_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        tx_err_o;
  logic        rx_misroute_o;
  logic [15:0] tx_pckt_cnt_o;
  logic [15:0] rx_pckt_cnt_o;

  int checks = 0;
  int fails = 0;
  int exp_tx_cnt = 0;
  int exp_rx_cnt = 0;
  logic [11:0] txq[$];
  logic [7:0]  rxq[$];
  logic [11:0] exp_p;
  logic [7:0]  exp_d;

  rsc_net_iface #(.X_CORD(1), .Y_CORD(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_data_i(tx_data_i), .tx_xaddr_i(tx_xaddr_i),
    .tx_yaddr_i(tx_yaddr_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .noc_pckt_o(noc_pckt_o),
    .noc_wren_o(noc_wren_o), .noc_full_i(noc_full_i),
    .noc_ovrflw_i(noc_ovrflw_i), .noc_pckt_i(noc_pckt_i),
    .noc_wren_i(noc_wren_i), .noc_full_o(noc_full_o),
    .noc_ovrflw_o(noc_ovrflw_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_err_o(tx_err_o), .rx_misroute_o(rx_misroute_o),
    .tx_pckt_cnt_o(tx_pckt_cnt_o), .rx_pckt_cnt_o(rx_pckt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready_o); end
    checks++; if (noc_wren_o !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b want 0", noc_wren_o); end
    checks++; if (noc_pckt_o !== 12'h0) begin fails++; $display("FAIL reset_pckt: got %h want 000", noc_pckt_o); end
    checks++; if (noc_full_o !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", noc_full_o); end
    checks++; if (noc_ovrflw_o !== 1'b0) begin fails++; $display("FAIL reset_ovrflw: got %b want 0", noc_ovrflw_o); end
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (rx_data_o !== 8'h0) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data_o); end
    checks++; if (tx_err_o !== 1'b0) begin fails++; $display("FAIL reset_tx_err: got %b want 0", tx_err_o); end
    checks++; if (rx_misroute_o !== 1'b0) begin fails++; $display("FAIL reset_misroute: got %b want 0", rx_misroute_o); end
    checks++; if (tx_pckt_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_tx_cnt: got %0d want 0", tx_pckt_cnt_o); end
    checks++; if (rx_pckt_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_rx_cnt: got %0d want 0", rx_pckt_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_tx_basic();
    @(negedge clk_i);
    tx_data_i = 8'hA5; tx_xaddr_i = 2'd2; tx_yaddr_i = 2'd0; tx_valid_i = 1'b1;
    txq.push_back(12'h8A5);
    #1;
    checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL txb_ready: got %b want 1", tx_ready_o); end
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    #1;
    checks++; if (noc_wren_o !== 1'b1) begin fails++; $display("FAIL txb_wren: got %b want 1", noc_wren_o); end
    exp_p = txq.pop_front(); exp_tx_cnt++;
    checks++; if (noc_pckt_o !== exp_p) begin fails++; $display("FAIL txb_pckt: got %h want %h", noc_pckt_o, exp_p); end
    @(negedge clk_i); #1;
    checks++; if (noc_wren_o !== 1'b0) begin fails++; $display("FAIL txb_single: got %b want 0", noc_wren_o); end
    checks++; if (tx_pckt_cnt_o !== 16'(exp_tx_cnt)) begin fails++; $display("FAIL txb_cnt: got %0d want %0d", tx_pckt_cnt_o, exp_tx_cnt); end
  endtask

  task automatic test_tx_backpressure();
    @(negedge clk_i);
    noc_full_i = 1'b1;
    tx_data_i = 8'h3C; tx_xaddr_i = 2'd1; tx_yaddr_i = 2'd3; tx_valid_i = 1'b1;
    txq.push_back(12'h73C);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    repeat (5) begin
      #1;
      checks++; if (noc_wren_o !== 1'b0) begin fails++; $display("FAIL txbp_wren: got %b want 0", noc_wren_o); end
      checks++; if (tx_ready_o !== 1'b0) begin fails++; $display("FAIL txbp_ready: got %b want 0", tx_ready_o); end
      checks++; if (noc_pckt_o !== txq[0]) begin fails++; $display("FAIL txbp_hold: got %h want %h", noc_pckt_o, txq[0]); end
      @(negedge clk_i);
    end
    noc_full_i = 1'b0;
    #1;
    checks++; if (noc_wren_o !== 1'b1) begin fails++; $display("FAIL txbp_release: got %b want 1", noc_wren_o); end
    exp_p = txq.pop_front(); exp_tx_cnt++;
    checks++; if (noc_pckt_o !== exp_p) begin fails++; $display("FAIL txbp_pckt: got %h want %h", noc_pckt_o, exp_p); end
    @(negedge clk_i); #1;
    checks++; if (noc_wren_o !== 1'b0) begin fails++; $display("FAIL txbp_once: got %b want 0", noc_wren_o); end
    checks++; if (tx_pckt_cnt_o !== 16'(exp_tx_cnt)) begin fails++; $display("FAIL txbp_cnt: got %0d want %0d", tx_pckt_cnt_o, exp_tx_cnt); end
    checks++; if (tx_err_o !== 1'b0) begin fails++; $display("FAIL txbp_err_pre: got %b want 0", tx_err_o); end
    noc_ovrflw_i = 1'b1;
    @(negedge clk_i);
    noc_ovrflw_i = 1'b0;
    repeat (3) begin
      #1;
      checks++; if (tx_err_o !== 1'b1) begin fails++; $display("FAIL txbp_err_sticky: got %b want 1", tx_err_o); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      tx_data_i = 8'h10 + 8'(i); tx_xaddr_i = 2'(i); tx_yaddr_i = 2'(3 - i);
      tx_valid_i = 1'b1;
      txq.push_back({2'(i), 2'(3 - i), 8'h10 + 8'(i)});
      #1;
      checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b want 1", i, tx_ready_o); end
      if (noc_wren_o) begin
        exp_p = txq.pop_front(); exp_tx_cnt++;
        checks++; if (noc_pckt_o !== exp_p) begin fails++; $display("FAIL b2b_pckt%0d: got %h want %h", i, noc_pckt_o, exp_p); end
      end
    end
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    for (int c = 0; c < 10 && txq.size() > 0; c++) begin
      #1;
      if (noc_wren_o) begin
        exp_p = txq.pop_front(); exp_tx_cnt++;
        checks++; if (noc_pckt_o !== exp_p) begin fails++; $display("FAIL b2b_tail: got %h want %h", noc_pckt_o, exp_p); end
      end
      @(negedge clk_i);
    end
    checks++; if (txq.size() != 0) begin fails++; $display("FAIL b2b_timeout: got %0d pending want 0", txq.size()); txq.delete(); end
    checks++; if (tx_pckt_cnt_o !== 16'(exp_tx_cnt)) begin fails++; $display("FAIL b2b_cnt: got %0d want %0d", tx_pckt_cnt_o, exp_tx_cnt); end
  endtask

  task automatic test_rx_fill();
    rx_ready_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk_i);
      if (i == 8) begin
        checks++; if (noc_full_o !== 1'b0) begin fails++; $display("FAIL rx_full_early: got %b want 0", noc_full_o); end
      end
      if (i == 9) begin
        checks++; if (noc_full_o !== 1'b1) begin fails++; $display("FAIL rx_full: got %b want 1", noc_full_o); end
      end
      noc_pckt_i = 12'h500 + 12'(i);
      noc_wren_i = 1'b1;
      if (i <= 8) begin rxq.push_back(8'(i)); exp_rx_cnt++; end
    end
    @(negedge clk_i);
    noc_wren_i = 1'b0;
    #1;
    checks++; if (noc_ovrflw_o !== 1'b1) begin fails++; $display("FAIL rx_ovrflw: got %b want 1", noc_ovrflw_o); end
    checks++; if (rx_pckt_cnt_o !== 16'(exp_rx_cnt)) begin fails++; $display("FAIL rx_cnt: got %0d want %0d", rx_pckt_cnt_o, exp_rx_cnt); end
    @(negedge clk_i); #1;
    checks++; if (noc_ovrflw_o !== 1'b0) begin fails++; $display("FAIL rx_ovrflw_pulse: got %b want 0", noc_ovrflw_o); end
    rx_ready_i = 1'b1;
    for (int c = 0; c < 20 && rxq.size() > 0; c++) begin
      if (rx_valid_o) begin
        exp_d = rxq.pop_front();
        checks++; if (rx_data_o !== exp_d) begin fails++; $display("FAIL rx_drain: got %h want %h", rx_data_o, exp_d); end
      end
      @(negedge clk_i); #1;
    end
    checks++; if (rxq.size() != 0) begin fails++; $display("FAIL rx_drain_timeout: got %0d left want 0", rxq.size()); rxq.delete(); end
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL rx_empty: got %b want 0", rx_valid_o); end
    rx_ready_i = 1'b0;
  endtask

  task automatic test_misroute();
    @(negedge clk_i);
    noc_pckt_i = 12'h233;
    noc_wren_i = 1'b1;
    @(negedge clk_i);
    noc_wren_i = 1'b0;
    #1;
`ifdef RSC_NI_ADDR_CHECK_EN
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL mis_valid: got %b want 0", rx_valid_o); end
    checks++; if (rx_misroute_o !== 1'b1) begin fails++; $display("FAIL mis_flag: got %b want 1", rx_misroute_o); end
    checks++; if (rx_pckt_cnt_o !== 16'(exp_rx_cnt)) begin fails++; $display("FAIL mis_cnt: got %0d want %0d", rx_pckt_cnt_o, exp_rx_cnt); end
`else
    rxq.push_back(8'h33); exp_rx_cnt++;
    checks++; if (rx_valid_o !== 1'b1) begin fails++; $display("FAIL mis_valid: got %b want 1", rx_valid_o); end
    exp_d = rxq.pop_front();
    checks++; if (rx_data_o !== exp_d) begin fails++; $display("FAIL mis_data: got %h want %h", rx_data_o, exp_d); end
    checks++; if (rx_misroute_o !== 1'b0) begin fails++; $display("FAIL mis_flag: got %b want 0", rx_misroute_o); end
    checks++; if (rx_pckt_cnt_o !== 16'(exp_rx_cnt)) begin fails++; $display("FAIL mis_cnt: got %0d want %0d", rx_pckt_cnt_o, exp_rx_cnt); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    #1;
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL mis_pop: got %b want 0", rx_valid_o); end
`endif
  endtask

  task automatic test_simul_push_pop();
    @(negedge clk_i);
    noc_pckt_i = 12'h511; noc_wren_i = 1'b1;
    rxq.push_back(8'h11); exp_rx_cnt++;
    @(negedge clk_i);
    noc_pckt_i = 12'h522; rx_ready_i = 1'b1;
    rxq.push_back(8'h22); exp_rx_cnt++;
    #1;
    checks++; if (rx_valid_o !== 1'b1) begin fails++; $display("FAIL sim_valid: got %b want 1", rx_valid_o); end
    exp_d = rxq.pop_front();
    checks++; if (rx_data_o !== exp_d) begin fails++; $display("FAIL sim_first: got %h want %h", rx_data_o, exp_d); end
    @(negedge clk_i);
    noc_wren_i = 1'b0; rx_ready_i = 1'b0;
    #1;
    checks++; if (rx_valid_o !== 1'b1) begin fails++; $display("FAIL sim_valid2: got %b want 1", rx_valid_o); end
    checks++; if (noc_full_o !== 1'b0) begin fails++; $display("FAIL sim_full: got %b want 0", noc_full_o); end
    exp_d = rxq.pop_front();
    checks++; if (rx_data_o !== exp_d) begin fails++; $display("FAIL sim_second: got %h want %h", rx_data_o, exp_d); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    #1;
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL sim_count1: got %b want 0", rx_valid_o); end
    checks++; if (rx_pckt_cnt_o !== 16'(exp_rx_cnt)) begin fails++; $display("FAIL sim_cnt: got %0d want %0d", rx_pckt_cnt_o, exp_rx_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    noc_full_i = 1'b1;
    tx_data_i = 8'h77; tx_xaddr_i = 2'd3; tx_yaddr_i = 2'd1; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      noc_pckt_i = 12'h540 + 12'(i); noc_wren_i = 1'b1;
      @(negedge clk_i);
    end
    noc_wren_i = 1'b0;
    #1;
    checks++; if (noc_pckt_o !== 12'hD77) begin fails++; $display("FAIL rm_pending: got %h want d77", noc_pckt_o); end
    checks++; if (rx_valid_o !== 1'b1) begin fails++; $display("FAIL rm_rx_loaded: got %b want 1", rx_valid_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL rm_ready: got %b want 1", tx_ready_o); end
    checks++; if (noc_pckt_o !== 12'h0) begin fails++; $display("FAIL rm_pckt: got %h want 000", noc_pckt_o); end
    checks++; if (noc_wren_o !== 1'b0) begin fails++; $display("FAIL rm_wren: got %b want 0", noc_wren_o); end
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL rm_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (rx_data_o !== 8'h0) begin fails++; $display("FAIL rm_rx_data: got %h want 00", rx_data_o); end
    checks++; if (tx_err_o !== 1'b0) begin fails++; $display("FAIL rm_tx_err: got %b want 0", tx_err_o); end
    checks++; if (tx_pckt_cnt_o !== 16'd0) begin fails++; $display("FAIL rm_tx_cnt: got %0d want 0", tx_pckt_cnt_o); end
    checks++; if (rx_pckt_cnt_o !== 16'd0) begin fails++; $display("FAIL rm_rx_cnt: got %0d want 0", rx_pckt_cnt_o); end
    noc_full_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    checks++; if (noc_wren_o !== 1'b0) begin fails++; $display("FAIL rm_after_wren: got %b want 0", noc_wren_o); end
    checks++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL rm_after_rx: got %b want 0", rx_valid_o); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_backpressure();
    test_back_to_back();
    test_rx_fill();
    test_misroute();
    test_simul_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
